stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Self-managing LIFO stack for the CPU data and return stacks.
- Holds top-of-stack (TOS) in a register; deeper entries live in an internal register array.
- Owns its pointer, occupancy count, full/empty status and sticky error flags, so the core issues only push/pop/replace.
- Adds a combinational pick port for deep reads and a selectable overflow policy: saturating, or J1-style circular wrap.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 4: pointer width. Total capacity CAP = 2**DEPTH entries, including TOS.
- WRAP, 0: 0 = saturate (illegal ops ignored); 1 = circular (pointer wraps, oldest data lost).

Ports:
- clk  in  1: clock, rising edge.
- resetq  in  1: reset, asynchronous, active-high.
- push  in  1: push wd.
- pop  in  1: pop TOS. push&pop together = replace TOS with wd.
- wd  in  WIDTH: write data.
- tos  out  WIDTH: top of stack (registered).
- nos  out  WIDTH: next-on-stack, combinational = store[sp-1]. Meaningful when count>=2.
- pick_idx  in  DEPTH: entry index, 0 = TOS.
- pick_data  out  WIDTH: combinational. tos if pick_idx==0, else store[sp-pick_idx] (mod 2**DEPTH). Meaningful when pick_idx<count.
- count  out  DEPTH+1: occupancy, 0..CAP.
- empty  out  1: count==0.
- full  out  1: count==CAP.
- overflow  out  1: sticky, push while full.
- underflow  out  1: sticky, pop or replace while empty.
- clr_err  in  1: clear sticky flags.

Behaviour:
- State:
  - tos register, WIDTH bits.
  - sp, DEPTH bits: next free slot in store[0:2**DEPTH-1].
  - count register.
  - overflow and underflow flags.
- Reset (async, active-high, any time including mid-operation): tos=0, sp=0, count=0, overflow=0, underflow=0. The array is not reset. empty=1, full=0 immediately.
- All state updates occur on the rising clk edge, with single-cycle latency. tos, count, empty and full reflect an op on the edge after it is issued.
- nos and pick_data follow sp/store combinationally. A write and a read of the same slot in one cycle returns the old data; there is no bypass.
- Idle (push=0, pop=0): hold.
- Push (push=1, pop=0):
  - If count<CAP: store[sp]<=tos (only if count>0); tos<=wd; sp<=sp+1; count<=count+1.
  - If full and WRAP=0: no state change; overflow<=1.
  - If full and WRAP=1: store[sp]<=tos; tos<=wd; sp<=sp+1 (wraps); count stays CAP; overflow<=1. The oldest entry is lost.
- Pop (push=0, pop=1):
  - If count>0: tos<=store[sp-1]; sp<=sp-1; count<=count-1. When count goes 1->0, tos still loads store[sp-1]; its value is don't-care.
  - If empty and WRAP=0: no change; underflow<=1.
  - If empty and WRAP=1: tos<=store[sp-1]; sp<=sp-1 (wraps); count stays 0; underflow<=1.
- Replace (push=1, pop=1):
  - If count>0: tos<=wd; sp and count unchanged; no store write.
  - If empty: no change in either mode; underflow<=1.
- Flags:
  - clr_err=1 clears both flags on the edge.
  - If an error occurs in the same cycle as clr_err, the set wins.
  - Flags never self-clear.
- Arithmetic:
  - sp is always modulo 2**DEPTH.
  - count never exceeds CAP and never goes below 0.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles -> tos=0xC, nos=0xB, pick_idx=2 gives 0xA, count=3, empty=0.
- Two pops from that state -> tos=0xB, then tos=0xA; count=1. A third pop -> count=0, empty=1, underflow stays 0.
- WRAP=0, DEPTH=2: push 1,2,3,4,5 -> full=1 after the 4th push; the 5th is ignored with tos=4, count=4, overflow=1. Four pops return tos 3,2,1 and count reaches 0.
- WRAP=1, DEPTH=2: push 1..5 -> tos=5, count=4, overflow=1, pick 1..3 = 4,3,2. Pop on empty sets underflow with count held at 0.
- Replace with count=2 and tos=7, wd=9 -> tos=9, count=2, nos unchanged. Replace when empty -> underflow=1, tos unchanged.
- Assert resetq mid-stream with count=3 (no clk edge) -> count=0, tos=0, flags=0 immediately. clr_err in the same cycle as an overflowing push -> overflow=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// LIFO stack with registered top-of-stack, register-array body, occupancy tracking,
// sticky error flags, a combinational deep-read port and selectable full/empty policy.
module stack_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    input  logic [DEPTH-1:0] pick_idx,
    output logic [WIDTH-1:0] pick_data,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int             CAP  = 2 ** DEPTH;
    localparam logic [DEPTH:0] CAPV = (DEPTH + 1)'(CAP);

    logic [WIDTH-1:0] store [CAP];
    logic [DEPTH-1:0] sp, sp_n, sp_m1, pick_addr;
    logic [DEPTH:0]   count_n;
    logic [WIDTH-1:0] tos_n;
    logic             ovf_n, unf_n, store_we;

    assign sp_m1     = sp - DEPTH'(1);
    assign pick_addr = sp - pick_idx;
    assign empty     = (count == '0);
    assign full      = (count == CAPV);
    assign nos       = store[sp_m1];
    assign pick_data = (pick_idx == '0) ? tos : store[pick_addr];

    always_comb begin
        sp_n     = sp;
        count_n  = count;
        tos_n    = tos;
        store_we = 1'b0;
        // clear first so an error raised in the same cycle overrides it
        ovf_n    = overflow & ~clr_err;
        unf_n    = underflow & ~clr_err;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    store_we = !empty;
                    tos_n    = wd;
                    sp_n     = sp + DEPTH'(1);
                    count_n  = count + (DEPTH + 1)'(1);
                end else begin
                    ovf_n = 1'b1;
                    if (WRAP != 0) begin
                        store_we = 1'b1;
                        tos_n    = wd;
                        sp_n     = sp + DEPTH'(1);
                    end
                end
            end
            2'b01: begin
                if (!empty) begin
                    tos_n   = store[sp_m1];
                    sp_n    = sp_m1;
                    count_n = count - (DEPTH + 1)'(1);
                end else begin
                    unf_n = 1'b1;
                    if (WRAP != 0) begin
                        tos_n = store[sp_m1];
                        sp_n  = sp_m1;
                    end
                end
            end
            2'b11: begin
                if (!empty) tos_n = wd;
                else        unf_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            tos       <= '0;
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_n;
            sp        <= sp_n;
            count     <= count_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end

    // body storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (store_we) store[sp] <= tos;
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: three configurations driven in parallel, checked against an
// abstract array-of-entries model, table vectors and hand-written corner sequences.
module tb_stack_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetq, push, pop, clr_err;
    logic [31:0] wd;
    int          pk;
    logic [3:0]  pidx0;
    logic [1:0]  pidx12;
    assign pidx0  = 4'(pk);
    assign pidx12 = 2'(pk);

    logic [31:0] tos0, nos0, pick0, tos1, nos1, pick1, tos2, nos2, pick2;
    logic [4:0]  cnt0;
    logic [2:0]  cnt1, cnt2;
    logic        emp0, full0, ovf0, unf0, emp1, full1, ovf1, unf1, emp2, full2, ovf2, unf2;

    stack_ctrl #(.WIDTH(32), .DEPTH(4), .WRAP(0)) u0 (
        .clk(clk), .resetq(resetq), .push(push), .pop(pop), .wd(wd), .tos(tos0), .nos(nos0),
        .pick_idx(pidx0), .pick_data(pick0), .count(cnt0), .empty(emp0), .full(full0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err));
    stack_ctrl #(.WIDTH(32), .DEPTH(2), .WRAP(0)) u1 (
        .clk(clk), .resetq(resetq), .push(push), .pop(pop), .wd(wd), .tos(tos1), .nos(nos1),
        .pick_idx(pidx12), .pick_data(pick1), .count(cnt1), .empty(emp1), .full(full1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err));
    stack_ctrl #(.WIDTH(32), .DEPTH(2), .WRAP(1)) u2 (
        .clk(clk), .resetq(resetq), .push(push), .pop(pop), .wd(wd), .tos(tos2), .nos(nos2),
        .pick_idx(pidx12), .pick_data(pick2), .count(cnt2), .empty(emp2), .full(full2),
        .overflow(ovf2), .underflow(unf2), .clr_err(clr_err));

    logic [31:0] o_tos[3], o_nos[3], o_pick[3], o_cnt[3];
    logic        o_emp[3], o_full[3], o_ovf[3], o_unf[3];
    assign o_tos[0] = tos0;  assign o_tos[1] = tos1;  assign o_tos[2] = tos2;
    assign o_nos[0] = nos0;  assign o_nos[1] = nos1;  assign o_nos[2] = nos2;
    assign o_pick[0] = pick0; assign o_pick[1] = pick1; assign o_pick[2] = pick2;
    assign o_cnt[0] = 32'(cnt0); assign o_cnt[1] = 32'(cnt1); assign o_cnt[2] = 32'(cnt2);
    assign o_emp[0] = emp0;  assign o_emp[1] = emp1;  assign o_emp[2] = emp2;
    assign o_full[0] = full0; assign o_full[1] = full1; assign o_full[2] = full2;
    assign o_ovf[0] = ovf0;  assign o_ovf[1] = ovf1;  assign o_ovf[2] = ovf2;
    assign o_unf[0] = unf0;  assign o_unf[1] = unf1;  assign o_unf[2] = unf2;

    // Model: live entries kept bottom-to-top in mstk[k][0..mcnt-1]; top is the last one.
    int          cap[3]   = '{16, 4, 4};
    bit          wrapm[3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] mstk[3][16];
    int          mcnt[3];
    logic [31:0] etos[3];
    bit          eknown[3], movf[3], munf[3];

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; etos[k] = '0; eknown[k] = 1'b1; movf[k] = 1'b0; munf[k] = 1'b0;
        end
    endtask

    task automatic model_op(input int k, input bit ps, input bit pp, input logic [31:0] d,
                            input bit clr);
        bit eo, eu;
        eo = 1'b0; eu = 1'b0;
        if (ps && !pp) begin
            if (mcnt[k] < cap[k]) begin
                mstk[k][mcnt[k]] = d; mcnt[k]++;
            end else begin
                eo = 1'b1;
                if (wrapm[k]) begin
                    for (int i = 0; i < cap[k] - 1; i++) mstk[k][i] = mstk[k][i+1];
                    mstk[k][cap[k]-1] = d;
                end
            end
        end else if (pp && !ps) begin
            if (mcnt[k] > 0) begin
                mcnt[k]--;
                if (mcnt[k] == 0) eknown[k] = 1'b0;
            end else begin
                eu = 1'b1;
                if (wrapm[k]) eknown[k] = 1'b0;
            end
        end else if (ps && pp) begin
            if (mcnt[k] > 0) mstk[k][mcnt[k]-1] = d;
            else eu = 1'b1;
        end
        if (clr) begin movf[k] = 1'b0; munf[k] = 1'b0; end
        if (eo) movf[k] = 1'b1;
        if (eu) munf[k] = 1'b1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int p;
            chk($sformatf("u%0d_count", k), o_cnt[k], 32'(mcnt[k]));
            chk($sformatf("u%0d_empty", k), 32'(o_emp[k]), 32'(mcnt[k] == 0));
            chk($sformatf("u%0d_full", k), 32'(o_full[k]), 32'(mcnt[k] == cap[k]));
            chk($sformatf("u%0d_overflow", k), 32'(o_ovf[k]), 32'(movf[k]));
            chk($sformatf("u%0d_underflow", k), 32'(o_unf[k]), 32'(munf[k]));
            if (mcnt[k] > 0) chk($sformatf("u%0d_tos", k), o_tos[k], mstk[k][mcnt[k]-1]);
            else if (eknown[k]) chk($sformatf("u%0d_tos_empty", k), o_tos[k], etos[k]);
            if (mcnt[k] >= 2) chk($sformatf("u%0d_nos", k), o_nos[k], mstk[k][mcnt[k]-2]);
            p = pk % cap[k];
            if (p < mcnt[k]) chk($sformatf("u%0d_pick%0d", k, p), o_pick[k], mstk[k][mcnt[k]-1-p]);
        end
    endtask

    task automatic step(input bit ps, input bit pp, input logic [31:0] d, input bit clr);
        push = ps; pop = pp; wd = d; clr_err = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_op(k, ps, pp, d, clr);
        @(negedge clk);
        #1;
        check_all();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        resetq = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetq = 1'b0;
        #1;
        check_all();
    endtask

    typedef struct {
        bit          ps;
        bit          pp;
        logic [31:0] d;
        logic [31:0] etos;
        bit          ctos;
        int          ecnt;
        bit          efull;
        bit          eovf;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 0, 32'd1, 32'd1, 1, 1, 0, 0};
        tbl[1] = '{1, 0, 32'd2, 32'd2, 1, 2, 0, 0};
        tbl[2] = '{1, 0, 32'd3, 32'd3, 1, 3, 0, 0};
        tbl[3] = '{1, 0, 32'd4, 32'd4, 1, 4, 1, 0};
        tbl[4] = '{1, 0, 32'd5, 32'd4, 1, 4, 1, 1};
        tbl[5] = '{0, 1, 32'd0, 32'd3, 1, 3, 0, 1};
        tbl[6] = '{0, 1, 32'd0, 32'd2, 1, 2, 0, 1};
        tbl[7] = '{0, 1, 32'd0, 32'd1, 1, 1, 0, 1};
        tbl[8] = '{0, 1, 32'd0, 32'd0, 0, 0, 0, 1};

        push = 0; pop = 0; wd = '0; clr_err = 0; pk = 0; resetq = 1;
        apply_reset();
        chk("reset_tos", tos0, 32'd0);
        chk("reset_empty", 32'(emp0), 32'd1);

        // basic push/pop on the deep instance
        pk = 2;
        step(1, 0, 32'hA, 0); step(1, 0, 32'hB, 0); step(1, 0, 32'hC, 0);
        chk("t1_tos", tos0, 32'hC);
        chk("t1_nos", nos0, 32'hB);
        chk("t1_pick2", pick0, 32'hA);
        chk("t1_count", o_cnt[0], 32'd3);
        pk = 0;
        step(0, 1, 0, 0); chk("t2_tos_b", tos0, 32'hB);
        step(0, 1, 0, 0); chk("t2_tos_a", tos0, 32'hA); chk("t2_count", o_cnt[0], 32'd1);
        step(0, 1, 0, 0); chk("t2_empty", 32'(emp0), 32'd1); chk("t2_unf", 32'(unf0), 32'd0);

        // saturating vs wrapping at CAP=4
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].ps, tbl[i].pp, tbl[i].d, 0);
            if (tbl[i].ctos) chk($sformatf("tbl%0d_tos", i), tos1, tbl[i].etos);
            chk($sformatf("tbl%0d_count", i), o_cnt[1], 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_full", i), 32'(full1), 32'(tbl[i].efull));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf1), 32'(tbl[i].eovf));
            if (i == 4) begin
                chk("wrap_tos", tos2, 32'd5);
                chk("wrap_count", o_cnt[2], 32'd4);
                chk("wrap_ovf", 32'(ovf2), 32'd1);
                for (int p = 1; p < 4; p++) begin
                    pk = p; #1;
                    chk($sformatf("wrap_pick%0d", p), pick2, 32'(5 - p));
                end
                pk = 0;
            end
        end
        step(0, 1, 0, 0);
        chk("wrap_unf", 32'(unf2), 32'd1);
        chk("wrap_unf_count", o_cnt[2], 32'd0);

        // replace
        apply_reset();
        step(1, 0, 32'd5, 0); step(1, 0, 32'd7, 0); step(1, 1, 32'd9, 0);
        chk("rep_tos", tos0, 32'd9); chk("rep_count", o_cnt[0], 32'd2); chk("rep_nos", nos0, 32'd5);
        apply_reset();
        step(1, 1, 32'h55, 0);
        chk("rep_empty_unf", 32'(unf0), 32'd1); chk("rep_empty_tos", tos0, 32'd0);

        // asynchronous reset mid-cycle with flags set and count=3
        step(1, 0, 32'h11, 0); step(1, 0, 32'h22, 0); step(1, 0, 32'h33, 0);
        #2;
        resetq = 1'b1;
        #1;
        chk("areset_count", o_cnt[0], 32'd0); chk("areset_tos", tos0, 32'd0);
        chk("areset_unf", 32'(unf0), 32'd0); chk("areset_empty", 32'(emp0), 32'd1);
        model_reset();
        @(negedge clk); resetq = 1'b0; #1; check_all();

        // set beats clear, clear alone clears
        for (int i = 0; i < 4; i++) step(1, 0, 32'(i + 1), 0);
        step(1, 0, 32'h99, 1); chk("clr_vs_set", 32'(ovf1), 32'd1);
        step(0, 0, 0, 1);      chk("clr_only", 32'(ovf1), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            pk = int'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) apply_reset();
            else step(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, $urandom(),
                      $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
